// File: rtl/count_compare_pwm_if.sv
// Count/duty bus for count_compare_pwm: upstream counter samples plus the duty-update handshake.
// Handshake: a duty word transfers on a clk edge where duty_valid and duty_ready are both 1;
// the master holds duty_valid and duty_data stable until that edge, and duty_ready never depends on duty_valid.
interface count_compare_pwm_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] count_in;
    logic             count_valid;
    logic [WIDTH:0]   duty_data;
    logic             duty_valid;
    logic             duty_ready;

    modport master (
        output count_in, count_valid, duty_data, duty_valid,
        input  duty_ready
    );

    modport slave (
        input  count_in, count_valid, duty_data, duty_valid,
        output duty_ready
    );
endinterface

// File: rtl/count_compare_pwm.sv
// Count-compare PWM: registered pwm_out from count_in < duty, with duties double-buffered to wrap.
// Optional sticky wrap interrupt (irq_clr / wrap_irq) when WRAP_IRQ_STICKY_EN is defined.
module count_compare_pwm #(
    parameter int WIDTH    = 4,
    parameter int CYCLES_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    count_compare_pwm_if.slave  bus,
    output logic                pwm_out,
    output logic                wrap_pulse,
    output logic [CYCLES_W-1:0] period_cnt,
    output logic                state_dbg
`ifdef WRAP_IRQ_STICKY_EN
    ,
    input  logic                irq_clr,
    output logic                wrap_irq
`endif
);

    localparam logic [WIDTH:0] DUTY_MAX = {1'b1, {WIDTH{1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH:0]      active_q, active_d;
    logic [WIDTH:0]      pending_q, pending_d;
    logic                pending_full_q, pending_full_d;
    logic                pwm_d;
    logic                wrap_d;
    logic [CYCLES_W-1:0] period_d;

    logic                accept;
    logic                wrap;
    logic                duty_avail;
    logic [WIDTH:0]      duty_sat;

    assign bus.duty_ready = !reset && !pending_full_q;
    assign accept         = bus.duty_valid && bus.duty_ready;
    assign duty_sat       = (bus.duty_data > DUTY_MAX) ? DUTY_MAX : bus.duty_data;
    assign wrap           = bus.count_valid && (bus.count_in == {WIDTH{1'b1}});
    assign duty_avail     = pending_full_q || accept;
    assign state_dbg      = (state_q == RUN);

    always_comb begin
        state_d        = state_q;
        active_d       = active_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        pwm_d          = pwm_out;
        wrap_d         = 1'b0;
        period_d       = period_cnt;

        // The wrap sample is still compared against the old duty; a new duty starts at count 0.
        if (bus.count_valid) begin
            pwm_d = (state_q == RUN) && ({1'b0, bus.count_in} < active_q);
        end

        if (wrap && ((state_q == RUN) || duty_avail)) begin
            wrap_d  = 1'b1;
            state_d = RUN;
            if (state_q == RUN) begin
                period_d = period_cnt + 1'b1;
            end
            if (pending_full_q) begin
                active_d       = pending_q;
                pending_full_d = 1'b0;
            end else if (accept) begin
                active_d = duty_sat;
            end
        end else if (accept) begin
            pending_d      = duty_sat;
            pending_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            active_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            pwm_out        <= 1'b0;
            wrap_pulse     <= 1'b0;
            period_cnt     <= '0;
        end else begin
            state_q        <= state_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            pwm_out        <= pwm_d;
            wrap_pulse     <= wrap_d;
            period_cnt     <= period_d;
        end
    end

`ifdef WRAP_IRQ_STICKY_EN
    // Set has priority over clear so a wrap coinciding with irq_clr is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_irq <= 1'b0;
        end else if (wrap_pulse) begin
            wrap_irq <= 1'b1;
        end else if (irq_clr) begin
            wrap_irq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_count_compare_pwm.sv
// Bench for count_compare_pwm: directed period scenarios, randomized traffic and period_cnt rollover,
// all checked every cycle against a period-level behavioural model.
module tb_count_compare_pwm;

  logic       clk;
  logic       reset;
  logic       pwm_out;
  logic       wrap_pulse;
  logic [7:0] period_cnt;
  logic       state_dbg;
`ifdef WRAP_IRQ_STICKY_EN
  logic       irq_clr;
  logic       wrap_irq;
`endif

  count_compare_pwm_if #(.WIDTH(4)) cif ();

  count_compare_pwm #(.WIDTH(4), .CYCLES_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (cif),
    .pwm_out    (pwm_out),
    .wrap_pulse (wrap_pulse),
    .period_cnt (period_cnt),
    .state_dbg  (state_dbg)
`ifdef WRAP_IRQ_STICKY_EN
    ,
    .irq_clr    (irq_clr),
    .wrap_irq   (wrap_irq)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One period-level view: a running flag, the duty in force, and a queue of waiting duties.
  int running = 0;
  int active  = 0;
  int pend_q[$];
  int e_pwm = 0, e_wrap = 0, e_period = 0, e_irq = 0;
  bit m_acc = 1'b0;

  always @(posedge clk) begin
    bit acc, is_wrap;
    int d;
    if (reset) begin
      running = 0; active = 0; pend_q.delete();
      e_pwm = 0; e_wrap = 0; e_period = 0; e_irq = 0; m_acc = 1'b0;
    end else begin
      d       = (int'(cif.duty_data) > 16) ? 16 : int'(cif.duty_data);
      acc     = cif.duty_valid && (pend_q.size() == 0);
      is_wrap = cif.count_valid && (cif.count_in == 4'd15);
`ifdef WRAP_IRQ_STICKY_EN
      e_irq = e_wrap ? 1 : (irq_clr ? 0 : e_irq);
`endif
      e_wrap = 0;
      if (cif.count_valid) e_pwm = (running != 0 && int'(cif.count_in) < active) ? 1 : 0;
      if (is_wrap && (running != 0 || pend_q.size() > 0 || acc)) begin
        if (running != 0) e_period = (e_period + 1) % 256;
        running = 1;
        e_wrap  = 1;
        if (pend_q.size() > 0) active = pend_q.pop_front();
        else if (acc) active = d;
      end else if (acc) begin
        pend_q.push_back(d);
      end
      m_acc = acc;
    end
  end

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    #2;
    cmp("pwm_out", 32'(pwm_out), 32'(e_pwm));
    cmp("wrap_pulse", 32'(wrap_pulse), 32'(e_wrap));
    cmp("period_cnt", 32'(period_cnt), 32'(e_period));
    cmp("duty_ready", 32'(cif.duty_ready), 32'((!reset && pend_q.size() == 0) ? 1 : 0));
    cmp("state", 32'(state_dbg), 32'(running));
`ifdef WRAP_IRQ_STICKY_EN
    cmp("wrap_irq", 32'(wrap_irq), 32'(e_irq));
`endif
  end

  // ---------------- driver tasks ----------------
  logic [3:0] cnt;

  task automatic drive_cycle(input bit cv);
    @(negedge clk);
    if (m_acc) cif.duty_valid = 1'b0;
    cif.count_valid = cv;
    cif.count_in    = cnt;
    if (cv) cnt = cnt + 4'd1;
  endtask

  task automatic offer(input int d);
    cif.duty_valid = 1'b1;
    cif.duty_data  = 5'(d);
  endtask

  task automatic run_to_count(input logic [3:0] c);
    int n;
    n = 0;
    do begin
      drive_cycle(1'b1);
      n++;
    end while (cif.count_in != c && n < 40);
    if (cif.count_in != c) cmp("run_to_count_timeout", 32'(cif.count_in), 32'(c));
  endtask

  task automatic measure(output int highs);
    highs = 0;
    repeat (16) begin
      drive_cycle(1'b1);
      @(posedge clk);
      #2;
      highs += int'(pwm_out);
    end
  endtask

  task automatic apply_duty(input int d, output int highs);
    int n;
    n = 0;
    drive_cycle(1'b1);
    offer(d);
    @(posedge clk);
    #1;
    while (!m_acc && n < 40) begin
      drive_cycle(1'b1);
      @(posedge clk);
      #1;
      n++;
    end
    if (!m_acc) cmp("accept_timeout", 32'(m_acc), 32'd1);
    drive_cycle(1'b1);
    run_to_count(4'd15);
    measure(highs);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int h;
    reset = 1'b1;
    cnt = 4'd0;
    cif.count_in = 4'd0;
    cif.count_valid = 1'b0;
    cif.duty_data = 5'd0;
    cif.duty_valid = 1'b0;
`ifdef WRAP_IRQ_STICKY_EN
    irq_clr = 1'b0;
`endif
    repeat (3) drive_cycle(1'b1);
    cnt = 4'd0;
    reset = 1'b0;

    // idle with no duty offered
    repeat (40) drive_cycle(1'b1);
    @(posedge clk); #2;
    cmp("idle_pwm", 32'(pwm_out), 32'd0);
    cmp("idle_period", 32'(period_cnt), 32'd0);
    cmp("idle_ready", 32'(cif.duty_ready), 32'd1);

    // first duty, accepted mid-period
    run_to_count(4'd3);
    offer(5);
    run_to_count(4'd15);
    measure(h);
    cmp("duty5_highs", 32'(h), 32'd5);
    cmp("duty5_period", 32'(period_cnt), 32'd1);

    // double-buffering: 12 pending, then 2 held off until the wrap
    run_to_count(4'd3);
    offer(12);
    drive_cycle(1'b1);
    offer(2);
    #1;
    cmp("pending_full_ready", 32'(cif.duty_ready), 32'd0);
    run_to_count(4'd15);
    measure(h);
    cmp("duty12_highs", 32'(h), 32'd12);
    measure(h);
    cmp("duty2_highs", 32'(h), 32'd2);

    // extremes and saturation
    apply_duty(0, h);
    cmp("duty0_highs", 32'(h), 32'd0);
    apply_duty(16, h);
    cmp("duty16_highs", 32'(h), 32'd16);
    apply_duty(31, h);
    cmp("duty31_highs", 32'(h), 32'd16);

    // bypass: offer on the wrap sample with pending empty
    run_to_count(4'd14);
    drive_cycle(1'b1);
    offer(8);
    #1;
    cmp("bypass_ready", 32'(cif.duty_ready), 32'd1);
    measure(h);
    cmp("duty8_highs", 32'(h), 32'd8);

    // reset mid-period with a pending duty
    apply_duty(10, h);
    cmp("duty10_highs", 32'(h), 32'd10);
    run_to_count(4'd2);
    offer(3);
    run_to_count(4'd7);
    reset = 1'b1;
    @(posedge clk); #2;
    cmp("rst_pwm", 32'(pwm_out), 32'd0);
    cmp("rst_period", 32'(period_cnt), 32'd0);
    cmp("rst_state", 32'(state_dbg), 32'd0);
    drive_cycle(1'b1);
    reset = 1'b0;
    repeat (40) drive_cycle(1'b1);
    @(posedge clk); #2;
    cmp("rst_pending_lost", 32'(state_dbg), 32'd0);

    // randomized traffic: gaps, jumps, resets, random duties
    repeat (1500) begin
      if ($urandom_range(0, 19) == 0) cnt = 4'($urandom_range(0, 15));
      drive_cycle($urandom_range(0, 9) != 0);
      reset = ($urandom_range(0, 299) == 0);
      if (!cif.duty_valid && $urandom_range(0, 3) == 0) offer(int'($urandom_range(0, 31)));
`ifdef WRAP_IRQ_STICKY_EN
      irq_clr = ($urandom_range(0, 7) == 0);
`endif
    end
    reset = 1'b0;
`ifdef WRAP_IRQ_STICKY_EN
    irq_clr = 1'b0;
`endif

    // period_cnt rollover
    cif.duty_valid = 1'b0;
    reset = 1'b1;
    repeat (2) drive_cycle(1'b1);
    reset = 1'b0;
    cnt = 4'd0;
    run_to_count(4'd14);
    drive_cycle(1'b1);
    offer(7);
    repeat (255 * 16) begin
      drive_cycle(1'b1);
      if (!cif.duty_valid && $urandom_range(0, 7) == 0) offer(int'($urandom_range(0, 31)));
    end
    @(posedge clk); #2;
    cmp("period_255", 32'(period_cnt), 32'd255);
    repeat (16) drive_cycle(1'b1);
    @(posedge clk); #2;
    cmp("period_rollover", 32'(period_cnt), 32'd0);

    repeat (3) drive_cycle(1'b1);
    @(posedge clk); #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
